// File: rtl/triangle_bbox_scanner.sv
// Triangle bounding-box scanner: accepts three vertices, clips their bounding box
// to the screen and streams every pixel of the box row-major to the coverage test.
module triangle_bbox_scanner #(
    parameter int MAX_RESOLUTION_X = 1920,
    parameter int MAX_RESOLUTION_Y = 1080,
    localparam int XW = $clog2(MAX_RESOLUTION_X),
    localparam int YW = $clog2(MAX_RESOLUTION_Y)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tri_valid,
    output logic          tri_ready,
    input  logic [XW-1:0] tri_p1_x,
    input  logic [XW-1:0] tri_p2_x,
    input  logic [XW-1:0] tri_p3_x,
    input  logic [YW-1:0] tri_p1_y,
    input  logic [YW-1:0] tri_p2_y,
    input  logic [YW-1:0] tri_p3_y,
    output logic          pt_valid,
    input  logic          pt_ready,
    output logic [XW-1:0] pt_x,
    output logic [YW-1:0] pt_y,
    output logic          pt_last,
    output logic          done,
    output logic [1:0]    dbg_state_o
);

    // Both handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload stable while valid && !ready.

    typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;

    localparam logic [XW-1:0] X_LIM = XW'(MAX_RESOLUTION_X - 1);
    localparam logic [YW-1:0] Y_LIM = YW'(MAX_RESOLUTION_Y - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x1_q, x2_q, x3_q;
    logic [YW-1:0] y1_q, y2_q, y3_q;
    logic [XW-1:0] min_x_q, min_x_d, max_x_q, max_x_d;
    logic [YW-1:0] min_y_q, min_y_d, max_y_q, max_y_d;
    logic [XW-1:0] pt_x_q, pt_x_d;
    logic [YW-1:0] pt_y_q, pt_y_d;
    logic          pt_last_q, pt_last_d;
    logic          done_q, done_d;

    logic [XW-1:0] bx_min, bx_max;
    logic [YW-1:0] by_min, by_max;
    logic          accept;

    assign tri_ready   = (state_q == IDLE) && !rst;
    assign accept      = tri_valid && tri_ready;
    assign pt_valid    = (state_q == SCAN);
    assign pt_x        = pt_x_q;
    assign pt_y        = pt_y_q;
    assign pt_last     = pt_last_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

    // Bounding box of the captured vertices; only the max edges are clamped,
    // an off-screen min is detected and rejected in SETUP.
    always_comb begin
        bx_min = x1_q;
        bx_max = x1_q;
        if (x2_q < bx_min) bx_min = x2_q;
        if (x2_q > bx_max) bx_max = x2_q;
        if (x3_q < bx_min) bx_min = x3_q;
        if (x3_q > bx_max) bx_max = x3_q;
        if (bx_max > X_LIM) bx_max = X_LIM;

        by_min = y1_q;
        by_max = y1_q;
        if (y2_q < by_min) by_min = y2_q;
        if (y2_q > by_max) by_max = y2_q;
        if (y3_q < by_min) by_min = y3_q;
        if (y3_q > by_max) by_max = y3_q;
        if (by_max > Y_LIM) by_max = Y_LIM;
    end

    always_comb begin
        state_d   = state_q;
        min_x_d   = min_x_q;
        max_x_d   = max_x_q;
        min_y_d   = min_y_q;
        max_y_d   = max_y_q;
        pt_x_d    = pt_x_q;
        pt_y_d    = pt_y_q;
        pt_last_d = pt_last_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                if (bx_min > X_LIM || by_min > Y_LIM) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = SCAN;
                    min_x_d   = bx_min;
                    max_x_d   = bx_max;
                    min_y_d   = by_min;
                    max_y_d   = by_max;
                    pt_x_d    = bx_min;
                    pt_y_d    = by_min;
                    pt_last_d = (bx_min == bx_max) && (by_min == by_max);
                end
            end
            SCAN: begin
                if (pt_ready) begin
                    if (pt_last_q) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        pt_last_d = 1'b0;
                    end else begin
                        if (pt_x_q != max_x_q) begin
                            pt_x_d = pt_x_q + XW'(1);
                        end else begin
                            pt_x_d = min_x_q;
                            pt_y_d = pt_y_q + YW'(1);
                        end
                        pt_last_d = (pt_x_d == max_x_q) && (pt_y_d == max_y_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pt_x_q    <= '0;
            pt_y_q    <= '0;
            pt_last_q <= 1'b0;
            done_q    <= 1'b0;
            min_x_q   <= '0;
            max_x_q   <= '0;
            min_y_q   <= '0;
            max_y_q   <= '0;
        end else begin
            state_q   <= state_d;
            pt_x_q    <= pt_x_d;
            pt_y_q    <= pt_y_d;
            pt_last_q <= pt_last_d;
            done_q    <= done_d;
            min_x_q   <= min_x_d;
            max_x_q   <= max_x_d;
            min_y_q   <= min_y_d;
            max_y_q   <= max_y_d;
        end
    end

    // Vertex capture; inputs are free to change once the triangle is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
            y3_q <= '0;
        end else if (accept) begin
            x1_q <= tri_p1_x;
            x2_q <= tri_p2_x;
            x3_q <= tri_p3_x;
            y1_q <= tri_p1_y;
            y2_q <= tri_p2_y;
            y3_q <= tri_p3_y;
        end
    end

endmodule
